packet_store_fwd: RTL and testbench
===================================

PACKET_STORE_FWD -- requirements
Module: packet_store_fwd

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 9, the beat width, matching the packer output {flag, byte}.
REQ-002 The module SHALL have parameter DEPTH, default 16, the storage entries; power of two, minimum 4.
REQ-003 The module SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The module SHALL have port reset  input  1  reset; asynchronous, active-low.
REQ-005 The module SHALL have port s_axis_tdata  input  DATA_WIDTH  beat from upstream packer.
REQ-006 The module SHALL have ports s_axis_tvalid / s_axis_tlast  input  1 each  beat valid / last beat of packet.
REQ-007 The module SHALL have port s_axis_tready  output  1  input accept.
REQ-008 The module SHALL have port m_axis_tdata  output  DATA_WIDTH  stored beat.
REQ-009 The module SHALL have ports m_axis_tvalid / m_axis_tlast  output  1 each  output valid / last.
REQ-010 The module SHALL have port m_axis_tready  input  1  downstream accept.
REQ-011 The module SHALL have port pkt_count  output  clog2(DEPTH)+1  committed packets held.
REQ-012 The module SHALL have port drop_count  output  8  dropped packets, saturating at 255.
REQ-013 The module SHALL have port overflow  output  1  one-cycle pulse per dropped packet.

Function
REQ-014 The module SHALL be store-and-forward: no beat of a packet is presented on m_axis until that packet's tlast beat is written.
REQ-015 Storage SHALL hold {tlast, tdata} per entry; pointers wr_ptr, wr_commit, rd_ptr are clog2(DEPTH)+1 bits wide, wrapping modulo 2*DEPTH.
REQ-016 Occupancy SHALL equal wr_ptr - rd_ptr; full means occupancy == DEPTH.
REQ-017 Input transfer SHALL occur when s_axis_tvalid && s_axis_tready; s_axis_tready SHALL be 1 at all times out of reset (overflow drops, never stalls).
REQ-018 Write FSM states SHALL be IDLE, FILL, DROP; reset state IDLE.
REQ-019 IDLE/FILL, transfer, not full: write beat at wr_ptr, wr_ptr+1; tlast=0 goes to FILL; tlast=1 sets wr_commit to new wr_ptr, increments pkt_count, goes to IDLE.
REQ-020 IDLE/FILL, transfer, full: beat discarded, wr_ptr rewinds to wr_commit; tlast=0 goes to DROP; tlast=1 goes to IDLE, counts the drop.
REQ-021 DROP: all transferred beats discarded; on tlast go to IDLE, drop_count+1 (saturating), overflow pulses 1 cycle in the next cycle.
REQ-022 Full SHALL use registered occupancy; a read in the same cycle SHALL NOT prevent a drop.
REQ-023 Packets longer than DEPTH beats SHALL always be dropped.
REQ-024 m_axis_tvalid SHALL be 1 when rd_ptr != wr_commit; m_axis_tdata/tlast SHALL be the entry at rd_ptr (first-word fall-through, zero added latency).
REQ-025 Output transfer at m_axis_tvalid && m_axis_tready SHALL advance rd_ptr; transfer with m_axis_tlast=1 SHALL decrement pkt_count.
REQ-026 m_axis_tdata/tlast SHALL hold stable while m_axis_tvalid && !m_axis_tready.
REQ-027 Commit and output tlast transfer in the same cycle SHALL leave pkt_count unchanged.
REQ-028 Minimum latency SHALL be 1 cycle from the tlast write edge to m_axis_tvalid=1.

Reset
REQ-029 Asserting reset (low) SHALL immediately clear all pointers, pkt_count, drop_count, overflow, FSM=IDLE; m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=0.
REQ-030 Reset mid-packet SHALL discard all stored and partial packets; s_axis_tready SHALL return to 1 on the first edge after release.
REQ-031 Storage contents SHALL NOT require reset.

Verification
REQ-032 4-beat packet 0x101,0x002,0x003,0x004 (tlast on 4th), m_axis_tready=1 -> m_axis_tvalid rises the cycle after tlast write; same 4 beats out, tlast on 0x004; pkt_count 1 then 0.
REQ-033 Same packet with m_axis_tready=0 for 5 cycles -> m_axis_tvalid=1 with 0x101 held stable; pkt_count=1; release drains in 4 cycles.
REQ-034 20-beat packet, DEPTH=16, m_axis_tready=0 -> zero output beats, drop_count=1, one overflow pulse, pkt_count=0, occupancy 0.
REQ-035 Committed 10-beat packet then 8-beat packet, m_axis_tready=0 -> second packet dropped; first packet intact (10 beats); drop_count=1.
REQ-036 Reset low after 3 beats of a 6-beat packet -> outputs cleared immediately; fresh 2-beat packet after release passes intact.
REQ-037 300 oversize packets -> drop_count saturates at 255, overflow still pulses per drop.

Source files
------------

// File: rtl/packet_store_fwd.sv
// Store-and-forward packet buffer: beats are held until the packet's last beat
// lands, then forwarded first-word fall-through. Packets that do not fit are
// dropped whole (input never stalls) and counted.
module packet_store_fwd #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [$clog2(DEPTH):0]    pkt_count,
  output logic [7:0]                drop_count,
  output logic                      overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {StIdle, StFill, StDrop} wr_state_e;

  wr_state_e             r_state;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_wr_commit;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_ready;
  logic [PW-1:0]         r_pkt_count;
  logic [7:0]            r_drop_count;
  logic                  r_overflow;
  logic [DATA_WIDTH:0]   r_mem [DEPTH];

  logic [PW-1:0]         w_occ;
  logic                  w_full;
  logic                  w_in_xfer;
  logic                  w_write;
  logic                  w_commit;
  logic                  w_drop_evt;
  logic                  w_out_xfer;
  logic                  w_rd_last;
  logic [DATA_WIDTH:0]   w_rd_entry;

  // Occupancy is taken from registered pointers only, so a read in the same
  // cycle cannot rescue a beat that arrives while full.
  assign w_occ      = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_occ == PW'(DEPTH));
  assign w_in_xfer  = s_axis_tvalid & r_ready;
  assign w_write    = w_in_xfer & (r_state != StDrop) & ~w_full;
  assign w_commit   = w_write & s_axis_tlast;
  // Any accepted last beat that was not written ends a dropped packet.
  assign w_drop_evt = w_in_xfer & s_axis_tlast & ~w_write;

  assign w_rd_entry    = r_mem[r_rd_ptr[AW-1:0]];
  assign m_axis_tvalid = (r_rd_ptr != r_wr_commit);
  assign m_axis_tdata  = w_rd_entry[DATA_WIDTH-1:0];
  assign m_axis_tlast  = w_rd_entry[DATA_WIDTH] & m_axis_tvalid;
  assign w_out_xfer    = m_axis_tvalid & m_axis_tready;
  assign w_rd_last     = w_out_xfer & m_axis_tlast;

  assign s_axis_tready = r_ready;
  assign pkt_count     = r_pkt_count;
  assign drop_count    = r_drop_count;
  assign overflow      = r_overflow;

  // Write-side FSM: accept, commit on last beat, or rewind and drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_ready     <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_in_xfer) begin
        unique case (r_state)
          StIdle, StFill: begin
            if (!w_full) begin
              r_wr_ptr <= r_wr_ptr + PW'(1);
              if (s_axis_tlast) begin
                r_wr_commit <= r_wr_ptr + PW'(1);
                r_state     <= StIdle;
              end else begin
                r_state <= StFill;
              end
            end else begin
              r_wr_ptr <= r_wr_commit;
              r_state  <= s_axis_tlast ? StIdle : StDrop;
            end
          end
          StDrop: begin
            if (s_axis_tlast) r_state <= StIdle;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Read pointer advances on every output handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
    end else if (w_out_xfer) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  // Packet / drop bookkeeping; overflow pulses the cycle after a drop ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      unique case ({w_commit, w_rd_last})
        2'b10:   r_pkt_count <= r_pkt_count + PW'(1);
        2'b01:   r_pkt_count <= r_pkt_count - PW'(1);
        default: r_pkt_count <= r_pkt_count;
      endcase
      if (w_drop_evt && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      r_overflow <= w_drop_evt;
    end
  end

  // Storage array; contents are don't-care until committed, so no reset.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

endmodule

// File: tb/tb_packet_store_fwd.sv
module tb_packet_store_fwd;

  localparam int DW    = 9;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [4:0]    pkt_count;
  logic [7:0]    drop_count;
  logic          overflow;

  always #5 clk = ~clk;

  packet_store_fwd #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .overflow      (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int beats_out  = 0;
  int ovf_pulses = 0;
  int exp_drop   = 0;
  logic [DW:0] exp_q[$];

  function automatic void check(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Output monitor: sampled on the falling edge, between input updates.
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat  = '0;
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (overflow) ovf_pulses++;
      if (prev_stall) begin
        check("hold_valid", int'(m_tvalid), 1);
        check("hold_beat", int'({m_tlast, m_tdata}), int'(prev_beat));
      end
      if (m_tvalid && m_tready) begin
        int avail;
        avail = exp_q.size();
        beats_out++;
        check("out_beat_expected", int'(avail > 0), 1);
        if (avail > 0) check("out_beat", int'({m_tlast, m_tdata}), int'(exp_q.pop_front()));
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // First beat carries the flag bit, so base=1 gives 0x101,0x002,0x003,...
  task automatic send_pkt(input int len, input int base, input bit keep);
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tlast  = (i == len - 1);
      s_tdata  = {(i == 0), 8'(base + i)};
      if (keep) exp_q.push_back({s_tlast, s_tdata});
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    m_tready = 1'b1;
    while ((exp_q.size() != 0 || m_tvalid) && k < 300) begin
      tick();
      k++;
    end
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_tvalid_low"}, int'(m_tvalid), 0);
  endtask

  typedef struct {
    int len;
    int base;
    bit rdy;
    bit keep;
    int exp_pkt;
    int exp_drop;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int b0;
    vecs[0] = '{4,  8'h01, 1'b1, 1'b1, 1, 0};
    vecs[1] = '{1,  8'h20, 1'b1, 1'b1, 1, 0};
    vecs[2] = '{16, 8'h30, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{17, 8'h40, 1'b1, 1'b0, 0, 1};
    vecs[4] = '{20, 8'h50, 1'b0, 1'b0, 0, 2};
    vecs[5] = '{16, 8'h70, 1'b1, 1'b1, 1, 2};
    vecs[6] = '{5,  8'hA0, 1'b0, 1'b1, 1, 2};

    reset = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    #2;
    check("rst_tready", int'(s_tready), 0);
    check("rst_tvalid", int'(m_tvalid), 0);
    check("rst_tlast", int'(m_tlast), 0);
    check("rst_pkt_count", int'(pkt_count), 0);
    check("rst_drop_count", int'(drop_count), 0);
    check("rst_overflow", int'(overflow), 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("tready_before_edge", int'(s_tready), 0);
    tick();
    check("tready_after_release", int'(s_tready), 1);

    // Basic 4-beat packet: latency and pkt_count rise/fall.
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tlast  = (i == 3);
      s_tdata  = {(i == 0), 8'(1 + i)};
      exp_q.push_back({s_tlast, s_tdata});
      #1;
      check("no_output_before_commit", int'(m_tvalid), 0);
      tick();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    check("tvalid_after_commit", int'(m_tvalid), 1);
    check("first_beat_data", int'(m_tdata), 9'h101);
    check("pkt_count_one", int'(pkt_count), 1);
    repeat (4) tick();
    check("pkt_count_zero", int'(pkt_count), 0);
    check("basic_drained", exp_q.size(), 0);

    // Table of packets with fixed downstream ready during the input phase.
    for (int v = 0; v < 7; v++) begin
      m_tready = vecs[v].rdy;
      send_pkt(vecs[v].len, vecs[v].base, vecs[v].keep);
      check($sformatf("v%0d_pkt_after_send", v), int'(pkt_count), vecs[v].exp_pkt);
      drain($sformatf("v%0d", v));
      tick(); tick();
      check($sformatf("v%0d_pkt_final", v), int'(pkt_count), 0);
      check($sformatf("v%0d_drop_count", v), int'(drop_count), vecs[v].exp_drop);
      check($sformatf("v%0d_ovf_pulses", v), ovf_pulses, vecs[v].exp_drop);
    end
    exp_drop = 2;

    // Back-pressure: head beat held stable, then drains in 4 cycles.
    m_tready = 1'b0;
    send_pkt(4, 8'h01, 1'b1);
    repeat (5) tick();
    check("stall_tvalid", int'(m_tvalid), 1);
    check("stall_tdata", int'(m_tdata), 9'h101);
    check("stall_pkt_count", int'(pkt_count), 1);
    m_tready = 1'b1;
    k = 0;
    while (m_tvalid && k < 20) begin
      tick();
      k++;
    end
    check("stall_drain_cycles", k, 4);
    check("stall_pkt_zero", int'(pkt_count), 0);

    // 10-beat packet held; following 8-beat packet cannot fit and is dropped.
    m_tready = 1'b0;
    send_pkt(10, 8'h80, 1'b1);
    send_pkt(8, 8'h90, 1'b0);
    exp_drop++;
    tick(); tick();
    check("fit_pkt_count", int'(pkt_count), 1);
    check("fit_drop_count", int'(drop_count), exp_drop);
    check("fit_ovf_pulses", ovf_pulses, exp_drop);
    b0 = beats_out;
    drain("fit");
    check("fit_beats_out", beats_out - b0, 10);

    // Reset in the middle of a packet with a committed packet stored.
    m_tready = 1'b0;
    send_pkt(2, 8'hC0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = {(i == 0), 8'(8'hD0 + i)};
      tick();
    end
    s_tvalid = 1'b0;
    check("pre_reset_pkt", int'(pkt_count), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_tvalid", int'(m_tvalid), 0);
    check("mid_rst_tlast", int'(m_tlast), 0);
    check("mid_rst_tready", int'(s_tready), 0);
    check("mid_rst_pkt", int'(pkt_count), 0);
    check("mid_rst_drop", int'(drop_count), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    exp_q.delete();
    ovf_pulses = 0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_tready_back", int'(s_tready), 1);
    m_tready = 1'b1;
    send_pkt(2, 8'hE0, 1'b1);
    drain("post_reset");
    check("post_reset_pkt", int'(pkt_count), 0);

    // Oversize packets saturate the drop counter but keep pulsing overflow.
    m_tready = 1'b1;
    repeat (255) send_pkt(17, 8'h10, 1'b0);
    tick(); tick();
    check("sat_drop_255", int'(drop_count), 255);
    repeat (45) send_pkt(17, 8'h10, 1'b0);
    tick(); tick();
    check("sat_drop_hold", int'(drop_count), 255);
    check("sat_ovf_pulses", ovf_pulses, 300);
    check("sat_pkt_count", int'(pkt_count), 0);
    check("sat_tvalid", int'(m_tvalid), 0);
    check("sat_no_beats", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
